// File: rtl/bandpower_mc.sv
`default_nettype none
// ============================================================================
// Module      : bandpower_mc
// Description : Multi-channel band-power engine. Each bin's |X|^2 is
//               accumulated into runtime-configurable bands, and one packed
//               vector per frame is emitted with a valid/ready handshake.
//               The optional macro BANDPOWER_SMOOTH_EN adds per-channel
//               exponential smoothing.
// Revision    : 1.0 - initial release
// ============================================================================
module bandpower_mc #(
  parameter  int WIDTH       = 12,
  parameter  int BIN_NUM     = 4,
  parameter  int BAND_NUM    = 2,
  parameter  int CH_NUM      = 2,
  parameter  int FRAC_BITS   = 4,
  parameter  int OUT_WIDTH   = 26,
  parameter  int ALPHA_SHIFT = 2,
  localparam int IW = (BIN_NUM  > 1) ? $clog2(BIN_NUM)  : 1,
  localparam int CW = (CH_NUM   > 1) ? $clog2(CH_NUM)   : 1,
  localparam int BW = (BAND_NUM > 1) ? $clog2(BAND_NUM) : 1
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_rst,
  input  logic signed [WIDTH-1:0]       i_bin_re,
  input  logic signed [WIDTH-1:0]       i_bin_im,
  input  logic [IW-1:0]                 i_bin_idx,
  input  logic [CW-1:0]                 i_ch,
  input  logic                          i_bin_valid,
  input  logic                          i_bin_last,
  output logic                          o_bin_ready,
  input  logic                          i_cfg_wr,
  input  logic [BW-1:0]                 i_cfg_band,
  input  logic [IW-1:0]                 i_cfg_lo,
  input  logic [IW-1:0]                 i_cfg_hi,
  output logic [BAND_NUM*OUT_WIDTH-1:0] o_y,
  output logic [CW-1:0]                 o_ch,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_done
);

  localparam int PW = 2*WIDTH;
  localparam int AW = PW + IW;
  localparam int SW = AW + OUT_WIDTH;
`ifdef BANDPOWER_SMOOTH_EN
  localparam logic [1:0] FLUSH_LAST = 2'd3;
`else
  localparam logic [1:0] FLUSH_LAST = 2'd2;
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, OUTPUT} state_t;

  state_t                      r_state;
  logic [1:0]                  r_flush_cnt;
  logic [CW-1:0]               r_ch;
  logic [IW-1:0]               r_cfg_lo [BAND_NUM];
  logic [IW-1:0]               r_cfg_hi [BAND_NUM];
  logic [IW-1:0]               r_act_lo [BAND_NUM];
  logic [IW-1:0]               r_act_hi [BAND_NUM];
  logic signed [WIDTH-1:0]     r_s1_re, r_s1_im;
  logic [IW-1:0]               r_s1_idx, r_s2_idx;
  logic                        r_s1_vld, r_s2_vld;
  logic [PW-1:0]               r_s2_pow;
  logic [AW-1:0]               r_acc [BAND_NUM];
  logic signed [PW-1:0]        w_re2, w_im2;
  logic [PW-1:0]               w_pow;
  logic [BAND_NUM*OUT_WIDTH-1:0] w_y;
  logic                        w_bin_acc, w_hs, w_idx_ok;

  assign o_bin_ready = (r_state == IDLE) || (r_state == ACCUM);
  assign w_bin_acc   = i_bin_valid && o_bin_ready;
  assign w_hs        = o_valid && i_ready;
  assign o_done      = w_hs;
  assign w_re2       = r_s1_re * r_s1_re;
  assign w_im2       = r_s1_im * r_s1_im;
  assign w_pow       = $unsigned(w_re2) + $unsigned(w_im2);
  assign w_idx_ok    = int'(r_s2_idx) < BIN_NUM;

`ifdef BANDPOWER_SMOOTH_EN
  logic [OUT_WIDTH-1:0] r_s [CH_NUM][BAND_NUM];
  logic [CH_NUM-1:0]    r_seed;
  logic                 w_ch_ok, w_seeded;
  assign w_ch_ok  = int'(r_ch) < CH_NUM;
  assign w_seeded = w_ch_ok && r_seed[r_ch];
`endif

  for (genvar b = 0; b < BAND_NUM; b++) begin : g_band
    logic [SW-1:0]        w_ext;
    logic [OUT_WIDTH-1:0] w_p;
    assign w_ext = SW'(r_acc[b] >> FRAC_BITS);
    assign w_p   = (|w_ext[SW-1:OUT_WIDTH]) ? {OUT_WIDTH{1'b1}} : w_ext[OUT_WIDTH-1:0];
`ifdef BANDPOWER_SMOOTH_EN
    // Raw power is registered one cycle so the smoothing adder has its own stage.
    logic [OUT_WIDTH-1:0]    r_p;
    logic [OUT_WIDTH-1:0]    w_prev;
    logic signed [OUT_WIDTH:0] w_diff, w_sum;
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
      if (i_sys_rst) r_p <= '0;
      else           r_p <= w_p;
    end
    assign w_prev = w_ch_ok ? r_s[r_ch][b] : '0;
    assign w_diff = $signed({1'b0, r_p}) - $signed({1'b0, w_prev});
    assign w_sum  = $signed({1'b0, w_prev}) + (w_diff >>> ALPHA_SHIFT);
    assign w_y[b*OUT_WIDTH +: OUT_WIDTH] = w_seeded ? OUT_WIDTH'(w_sum) : r_p;
`else
    assign w_y[b*OUT_WIDTH +: OUT_WIDTH] = w_p;
`endif
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
      r_ch        <= '0;
      o_y         <= '0;
      o_ch        <= '0;
      o_valid     <= 1'b0;
      for (int b = 0; b < BAND_NUM; b++) begin
        r_cfg_lo[b] <= IW'(b*BIN_NUM/BAND_NUM);
        r_cfg_hi[b] <= IW'((b+1)*BIN_NUM/BAND_NUM - 1);
        r_act_lo[b] <= IW'(b*BIN_NUM/BAND_NUM);
        r_act_hi[b] <= IW'((b+1)*BIN_NUM/BAND_NUM - 1);
      end
`ifdef BANDPOWER_SMOOTH_EN
      r_seed <= '0;
      for (int c = 0; c < CH_NUM; c++)
        for (int b = 0; b < BAND_NUM; b++) r_s[c][b] <= '0;
`endif
    end else begin
      if (r_state == IDLE && i_cfg_wr && int'(i_cfg_band) < BAND_NUM) begin
        r_cfg_lo[i_cfg_band] <= i_cfg_lo;
        r_cfg_hi[i_cfg_band] <= i_cfg_hi;
      end
      case (r_state)
        IDLE: if (w_bin_acc) begin
          // Edges are frozen at frame start, before any same-cycle config write lands.
          for (int b = 0; b < BAND_NUM; b++) begin
            r_act_lo[b] <= r_cfg_lo[b];
            r_act_hi[b] <= r_cfg_hi[b];
          end
          r_ch        <= i_ch;
          r_flush_cnt <= '0;
          r_state     <= i_bin_last ? FLUSH : ACCUM;
        end
        ACCUM: if (w_bin_acc && i_bin_last) begin
          r_flush_cnt <= '0;
          r_state     <= FLUSH;
        end
        FLUSH: if (r_flush_cnt == FLUSH_LAST) begin
          o_y     <= w_y;
          o_ch    <= r_ch;
          o_valid <= 1'b1;
          r_state <= OUTPUT;
`ifdef BANDPOWER_SMOOTH_EN
          if (w_ch_ok) begin
            r_seed[r_ch] <= 1'b1;
            for (int b = 0; b < BAND_NUM; b++) r_s[r_ch][b] <= w_y[b*OUT_WIDTH +: OUT_WIDTH];
          end
`endif
        end else begin
          r_flush_cnt <= r_flush_cnt + 2'd1;
        end
        OUTPUT: if (i_ready) begin
          o_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      r_s1_vld <= 1'b0;
      r_s1_re  <= '0;
      r_s1_im  <= '0;
      r_s1_idx <= '0;
      r_s2_vld <= 1'b0;
      r_s2_pow <= '0;
      r_s2_idx <= '0;
      for (int b = 0; b < BAND_NUM; b++) r_acc[b] <= '0;
    end else begin
      r_s1_vld <= w_bin_acc;
      if (w_bin_acc) begin
        r_s1_re  <= i_bin_re;
        r_s1_im  <= i_bin_im;
        r_s1_idx <= i_bin_idx;
      end
      r_s2_vld <= r_s1_vld;
      r_s2_pow <= w_pow;
      r_s2_idx <= r_s1_idx;
      for (int b = 0; b < BAND_NUM; b++) begin
        if (w_hs)
          r_acc[b] <= '0;
        else if (r_s2_vld && w_idx_ok && r_s2_idx >= r_act_lo[b] && r_s2_idx <= r_act_hi[b])
          r_acc[b] <= r_acc[b] + AW'(r_s2_pow);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bandpower_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_bandpower_mc
// Description : Directed scoreboard bench for bandpower_mc (default widths and
//               a 16-bit-output instance for saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bandpower_mc;
  localparam int WIDTH = 12, BIN_NUM = 4, BAND_NUM = 2, CH_NUM = 2, FRAC_BITS = 4;
  localparam int OW_A = 26, OW_B = 16, ALPHA = 2;
`ifdef BANDPOWER_SMOOTH_EN
  localparam int LAT = 4;
  localparam bit SMOOTH = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit SMOOTH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic signed [WIDTH-1:0] bin_re, bin_im;
  logic [1:0] bin_idx, cfg_lo, cfg_hi;
  logic ch, bin_valid, bin_last, cfg_wr, cfg_band, ready;
  logic bin_ready_a, bin_ready_b, ch_a, ch_b, valid_a, valid_b, done_a, done_b;
  logic [2*OW_A-1:0] y_a;
  logic [2*OW_B-1:0] y_b;

  always #5 clk = ~clk;

  bandpower_mc #(.WIDTH(WIDTH), .BIN_NUM(BIN_NUM), .BAND_NUM(BAND_NUM), .CH_NUM(CH_NUM),
                 .FRAC_BITS(FRAC_BITS), .OUT_WIDTH(OW_A), .ALPHA_SHIFT(ALPHA)) u_dut_a (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_bin_re(bin_re), .i_bin_im(bin_im),
    .i_bin_idx(bin_idx), .i_ch(ch), .i_bin_valid(bin_valid), .i_bin_last(bin_last),
    .o_bin_ready(bin_ready_a), .i_cfg_wr(cfg_wr), .i_cfg_band(cfg_band),
    .i_cfg_lo(cfg_lo), .i_cfg_hi(cfg_hi), .o_y(y_a), .o_ch(ch_a), .o_valid(valid_a),
    .i_ready(ready), .o_done(done_a));

  bandpower_mc #(.WIDTH(WIDTH), .BIN_NUM(BIN_NUM), .BAND_NUM(BAND_NUM), .CH_NUM(CH_NUM),
                 .FRAC_BITS(FRAC_BITS), .OUT_WIDTH(OW_B), .ALPHA_SHIFT(ALPHA)) u_dut_b (
    .i_sys_clk(clk), .i_sys_rst(rst), .i_bin_re(bin_re), .i_bin_im(bin_im),
    .i_bin_idx(bin_idx), .i_ch(ch), .i_bin_valid(bin_valid), .i_bin_last(bin_last),
    .o_bin_ready(bin_ready_b), .i_cfg_wr(cfg_wr), .i_cfg_band(cfg_band),
    .i_cfg_lo(cfg_lo), .i_cfg_hi(cfg_hi), .o_y(y_b), .o_ch(ch_b), .o_valid(valid_b),
    .i_ready(ready), .o_done(done_b));

  typedef struct {
    logic [2*OW_A-1:0] ya;
    logic [2*OW_B-1:0] yb;
    logic              ch;
  } exp_t;

  exp_t   sb[$];
  int     f_re[$], f_im[$], f_idx[$];
  int     f_ch;
  int     m_lo[BAND_NUM], m_hi[BAND_NUM], m_act_lo[BAND_NUM], m_act_hi[BAND_NUM];
  longint m_s[2][CH_NUM][BAND_NUM];
  bit     m_seed[2][CH_NUM];
  int     checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < BAND_NUM; b++) begin
      m_lo[b] = b * BIN_NUM / BAND_NUM;
      m_hi[b] = (b + 1) * BIN_NUM / BAND_NUM - 1;
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH_NUM; c++) begin
        m_seed[d][c] = 1'b0;
        for (int b = 0; b < BAND_NUM; b++) m_s[d][c][b] = 0;
      end
    f_re.delete(); f_im.delete(); f_idx.delete();
    sb.delete();
  endtask

  task automatic model_frame_end();
    exp_t e;
    longint sum, p, s, mx;
    int ow;
    e.ya = '0; e.yb = '0; e.ch = 1'(f_ch);
    for (int d = 0; d < 2; d++) begin
      ow = (d == 0) ? OW_A : OW_B;
      mx = (64'd1 << ow) - 1;
      for (int b = 0; b < BAND_NUM; b++) begin
        sum = 0;
        for (int i = 0; i < f_re.size(); i++)
          if (f_idx[i] >= m_act_lo[b] && f_idx[i] <= m_act_hi[b] && f_idx[i] < BIN_NUM)
            sum += longint'(f_re[i]) * f_re[i] + longint'(f_im[i]) * f_im[i];
        p = sum >> FRAC_BITS;
        if (p > mx) p = mx;
        if (SMOOTH) begin
          if (!m_seed[d][f_ch]) s = p;
          else begin
            s = m_s[d][f_ch][b];
            s = s + ((p - s) >>> ALPHA);
          end
          m_s[d][f_ch][b] = s;
        end else s = p;
        if (d == 0) e.ya[b*OW_A +: OW_A] = OW_A'(s);
        else        e.yb[b*OW_B +: OW_B] = OW_B'(s);
      end
      if (SMOOTH) m_seed[d][f_ch] = 1'b1;
    end
    sb.push_back(e);
    f_re.delete(); f_im.delete(); f_idx.delete();
  endtask

  task automatic send_bin(input int re, input int im, input int idx, input int c, input bit last);
    int k;
    bin_re = WIDTH'(re); bin_im = WIDTH'(im); bin_idx = 2'(idx); ch = 1'(c);
    bin_last = last; bin_valid = 1'b1;
    k = 0;
    while (!bin_ready_a && k < 20) begin @(posedge clk); #1; k++; end
    if (k >= 20) begin
      checks++; errors++;
      $error("FAIL bin_ready_timeout: observed 0 expected 1");
    end
    if (f_re.size() == 0) begin
      f_ch = c;
      for (int b = 0; b < BAND_NUM; b++) begin m_act_lo[b] = m_lo[b]; m_act_hi[b] = m_hi[b]; end
    end
    f_re.push_back(re); f_im.push_back(im); f_idx.push_back(idx);
    @(posedge clk); #1;
    bin_valid = 1'b0; bin_last = 1'b0; cfg_wr = 1'b0;
    if (last) model_frame_end();
  endtask

  task automatic send_frame(input int c, input int r0, input int i0, input int r1, input int i1,
                            input int r2, input int i2, input int r3, input int i3);
    send_bin(r0, i0, 0, c, 1'b0);
    send_bin(r1, i1, 1, c, 1'b0);
    send_bin(r2, i2, 2, c, 1'b0);
    send_bin(r3, i3, 3, c, 1'b1);
  endtask

  task automatic cfg_idle(input int band, input int lo, input int hi);
    cfg_wr = 1'b1; cfg_band = 1'(band); cfg_lo = 2'(lo); cfg_hi = 2'(hi);
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    if (band < BAND_NUM) begin m_lo[band] = lo; m_hi[band] = hi; end
  endtask

  task automatic wait_out(input int hold);
    exp_t e;
    int k;
    k = 0;
    while (!valid_a && k < LAT + 10) begin @(posedge clk); #1; k++; end
    chk("latency", 64'(k), 64'(LAT));
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL scoreboard_empty: observed 0 expected 1");
      return;
    end
    e = sb.pop_front();
    chk("valid_b", 64'(valid_b), 64'd1);
    chk("bin_ready_busy", 64'(bin_ready_a), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_y", 64'(y_a), 64'(e.ya));
      chk("hold_valid", 64'(valid_a), 64'd1);
      chk("hold_done", 64'(done_a), 64'd0);
    end
    ready = 1'b1; #1;
    chk("done_pulse", 64'(done_a), 64'd1);
    chk("y_a", 64'(y_a), 64'(e.ya));
    chk("y_b", 64'(y_b), 64'(e.yb));
    chk("o_ch", 64'(ch_a), 64'(e.ch));
    @(posedge clk); #1;
    ready = 1'b0;
    chk("valid_after_hs", 64'(valid_a), 64'd0);
    chk("done_after_hs", 64'(done_a), 64'd0);
    chk("bin_ready_after_hs", 64'(bin_ready_a), 64'd1);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; #1;
    chk({tag, "_valid"}, 64'(valid_a), 64'd0);
    chk({tag, "_bin_ready"}, 64'(bin_ready_a), 64'd1);
    chk({tag, "_done"}, 64'(done_a), 64'd0);
    chk({tag, "_y"}, 64'(y_a), 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst = 1'b0; ready = 1'b0; bin_valid = 1'b0; bin_last = 1'b0; cfg_wr = 1'b0;
    bin_re = '0; bin_im = '0; bin_idx = '0; ch = 1'b0; cfg_band = 1'b0; cfg_lo = '0; cfg_hi = '0;
    model_reset();
    #2;
    do_reset("reset");
    chk("reset_ch", 64'(ch_a), 64'd0);

    // Default bands: expect 32 / 64, immediate handshake then held handshake.
    send_frame(0, 16, 0, 0, 16, 32, 0, 0, 0);
    wait_out(0);
    send_frame(0, 16, 0, 0, 16, 32, 0, 0, 0);
    wait_out(10);

    // Band0 = bins 1..3, band1 empty (lo > hi): expect 80 / 0.
    cfg_idle(0, 1, 3);
    cfg_idle(1, 3, 0);
    send_frame(0, 16, 0, 0, 16, 32, 0, 0, 0);
    wait_out(0);

    // Config write during ACCUM is ignored.
    send_bin(16, 0, 0, 0, 1'b0);
    cfg_wr = 1'b1; cfg_band = 1'b0; cfg_lo = 2'd0; cfg_hi = 2'd0;
    send_bin(0, 16, 1, 0, 1'b0);
    send_bin(32, 0, 2, 0, 1'b0);
    send_bin(0, 0, 3, 0, 1'b1);
    wait_out(0);

    // Write alongside first bin applies only from the next frame (80 then 96).
    cfg_wr = 1'b1; cfg_band = 1'b0; cfg_lo = 2'd0; cfg_hi = 2'd3;
    send_bin(16, 0, 0, 0, 1'b0);
    m_lo[0] = 0; m_hi[0] = 3;
    send_bin(0, 16, 1, 0, 1'b0);
    send_bin(32, 0, 2, 0, 1'b0);
    send_bin(0, 0, 3, 0, 1'b1);
    wait_out(0);
    send_frame(0, 16, 0, 0, 16, 32, 0, 0, 0);
    wait_out(0);

    // Single-bin frame goes straight from IDLE to FLUSH.
    send_bin(16, 16, 1, 1, 1'b1);
    wait_out(2);

    // Saturation: 26-bit instance gives 2^20 per band, 16-bit instance clamps.
    do_reset("rst_sat");
    send_frame(1, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048);
    wait_out(0);

    // Reset after two bins aborts the frame; the next full frame is clean.
    send_bin(16, 0, 0, 0, 1'b0);
    send_bin(0, 16, 1, 0, 1'b0);
    do_reset("rst_midframe");
    send_frame(0, 16, 0, 0, 16, 32, 0, 0, 0);
    wait_out(0);

    // Reset while the result is presented drops it.
    send_frame(0, 16, 0, 0, 16, 32, 0, 0, 0);
    k = 0;
    while (!valid_a && k < LAT + 10) begin @(posedge clk); #1; k++; end
    chk("midout_valid", 64'(valid_a), 64'd1);
    do_reset("rst_midout");

    // Channel 1 history across an interleaved channel 0 frame.
    send_frame(1, 0, 0, 0, 0, 32, 0, 0, 0);
    wait_out(0);
    send_frame(0, 16, 0, 0, 16, 32, 0, 0, 0);
    wait_out(0);
    send_frame(1, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_out(1);
    send_frame(1, 0, 0, 0, 0, 0, 0, 0, 0);
    wait_out(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
